// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the switch/button input conditioner.
// Defaults give a 1 ms debounce tick at 50 MHz and a 30 ms stability window.
package input_conditioner_pkg;

  localparam int CLK_PERIOD_NS = 20;
  localparam int TICK_NS       = 1_000_000;
  localparam int DEBOUNCE_MS   = 30;

  localparam int DEFAULT_PRESCALE     = TICK_NS / CLK_PERIOD_NS;
  localparam int DEFAULT_STABLE_TICKS = DEBOUNCE_MS;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_kind_e;

  // Ceiling log2, bounded loop so it stays a legal constant function.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/conditioner_channel.sv
// One input bit: synchroniser chain, tick-based debounce counter, and the
// committed level with its registered edge pulses and toggle latch.
module conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw_in,
  input  logic toggle_en,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_out,
  output logic commit
);

  localparam int CNT_W = clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   synced;
  logic                   differs;
  edge_kind_e             edge_kind;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign differs = (synced != level_out);
  assign commit  = tick && differs && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Any cycle where the input agrees with the committed level restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    edge_kind = EDGE_NONE;
    if (!differs) begin
      cnt_d = '0;
    end else if (tick) begin
      if (commit) begin
        cnt_d     = '0;
        edge_kind = synced ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      level_out  <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      toggle_out <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rise_pulse <= (edge_kind == EDGE_RISE);
      fall_pulse <= (edge_kind == EDGE_FALL);
      if (commit) begin
        level_out <= synced;
      end
      if ((edge_kind == EDGE_RISE) && toggle_en) begin
        toggle_out <= ~toggle_out;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch/button front end. A single shared prescaler produces
// the debounce tick for every channel; any_change flags a commit on any bit.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int              N_CH         = 8,
  parameter int              SYNC_STAGES  = 2,
  parameter int              PRESCALE     = DEFAULT_PRESCALE,
  parameter int              STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic [N_CH-1:0] RESET_VALUE  = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] toggle_en,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out,
  output logic            any_change
);

  localparam int PCNT_W = clog2(PRESCALE);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic              tick;
  logic [N_CH-1:0]   commit_vec;

  assign tick = enable && (pcnt_q == PCNT_LAST);

  // Frozen while enable is low so pending debounce counts simply hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (enable) begin
      pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |commit_vec;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_VALUE[i])
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .raw_in    (raw_in[i]),
      .toggle_en (toggle_en[i]),
      .level_out (level_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .toggle_out(toggle_out[i]),
      .commit    (commit_vec[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus pushes hand-computed commit
// events, a negedge monitor pops one whenever the DUT shows a pulse.
module tb_input_conditioner;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic [N_CH-1:0] raw_in = '0;
  logic [N_CH-1:0] toggle_en = '0;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic [N_CH-1:0] toggle_out;
  logic            any_change;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] tog;
  } exp_event_t;

  exp_event_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = -1;

  input_conditioner #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .PRESCALE    (4),
    .STABLE_TICKS(3),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .raw_in    (raw_in),
    .toggle_en (toggle_en),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out),
    .any_change(any_change)
  );

  always #10 clk = ~clk;

  // Edge index since reset release: edge 0 is the first edge with reset low.
  always @(posedge clk) cyc <= reset ? -1 : cyc + 1;

  always @(negedge clk) begin : monitor
    exp_event_t e;
    if (any_change || (rise_pulse != '0) || (fall_pulse != '0)) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_event: got cyc=%0d rise=%b fall=%b any=%b, required no event",
                 cyc, rise_pulse, fall_pulse, any_change);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || any_change !== 1'b1 || rise_pulse !== e.rise ||
            fall_pulse !== e.fall || level_out !== e.level || toggle_out !== e.tog) begin
          mismatched++;
          $display("[TB] FAIL commit_event: got cyc=%0d rise=%b fall=%b level=%b toggle=%b any=%b, required cyc=%0d rise=%b fall=%b level=%b toggle=%b any=1",
                   cyc, rise_pulse, fall_pulse, level_out, toggle_out, any_change,
                   e.cyc, e.rise, e.fall, e.level, e.tog);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic push_event(input int c, input logic [N_CH-1:0] rise,
                            input logic [N_CH-1:0] fall, input logic [N_CH-1:0] level,
                            input logic [N_CH-1:0] tog);
    exp_event_t e;
    e.cyc = c; e.rise = rise; e.fall = fall; e.level = level; e.tog = tog;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge just before edge n is sampled.
  task automatic wait_edge(input int n);
    int guard = 0;
    while (cyc != n - 1) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        $display("[TB] FAIL wait_timeout: got cyc=%0d, required %0d", cyc, n - 1);
        $fatal(1, "[TB] wait bound expired");
      end
    end
  endtask

  // Called at a negedge; holds reset for n_edges edges then checks reset state.
  task automatic apply_reset(input logic [N_CH-1:0] raw_hold, input int n_edges);
    reset  = 1'b1;
    raw_in = raw_hold;
    enable = 1'b1;
    repeat (n_edges) @(negedge clk);
    check_output("reset_level", level_out, 0);
    check_output("reset_rise", rise_pulse, 0);
    check_output("reset_fall", fall_pulse, 0);
    check_output("reset_toggle", toggle_out, 0);
    check_output("reset_any", any_change, 0);
  endtask

  task automatic apply_stimulus(input int edge_num, input logic [N_CH-1:0] raw, input logic en);
    wait_edge(edge_num);
    raw_in = raw;
    enable = en;
  endtask

  task automatic finish_scenario(input int end_edge, input string name);
    wait_edge(end_edge);
    check_output({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    @(negedge clk);

    // Clean rise: s sees 1 from edge 2, ticks at 3/7/11 commit on edge 11.
    apply_reset('0, 3);
    push_event(11, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    reset = 1'b0; raw_in = 4'b0001;
    finish_scenario(30, "clean_rise");

    // Bounce low at edges 6-7 clears the count of 2; restart gives 11/15/19.
    apply_reset('0, 3);
    push_event(19, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    reset = 1'b0; raw_in = 4'b0010;
    apply_stimulus(6, 4'b0000, 1'b1);
    apply_stimulus(8, 4'b0010, 1'b1);
    finish_scenario(40, "bounce");

    // Toggle: changes every 12 edges commit 11 edges later; last press has toggle_en off.
    apply_reset('0, 3);
    toggle_en = 4'b0100;
    push_event(11, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    push_event(23, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    push_event(35, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    push_event(47, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    push_event(59, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    push_event(71, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    push_event(83, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    reset = 1'b0; raw_in = 4'b0100;
    for (int j = 1; j <= 5; j++) begin
      apply_stimulus(12 * j, (j % 2 == 1) ? 4'b0000 : 4'b0100, 1'b1);
    end
    wait_edge(64);
    toggle_en = 4'b0000;
    apply_stimulus(72, 4'b0100, 1'b1);
    finish_scenario(100, "toggle");

    // Freeze: tick at 3 counts once, pcnt held at 1 over edges 5-49, then ticks 52 and 56.
    apply_reset('0, 3);
    push_event(56, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    reset = 1'b0; raw_in = 4'b1000;
    apply_stimulus(5, 4'b1000, 1'b0);
    apply_stimulus(50, 4'b1000, 1'b1);
    finish_scenario(70, "freeze");

    // Reset at edge 9 with a count of 2 pending; full latency again after release.
    apply_reset('0, 3);
    reset = 1'b0; raw_in = 4'b0001;
    wait_edge(9);
    apply_reset(4'b0001, 4);
    push_event(11, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    reset = 1'b0;
    finish_scenario(30, "reset_mid_count");

    // Simultaneous: all four channels commit on edge 11; toggles follow toggle_en.
    apply_reset('0, 3);
    toggle_en = 4'b0101;
    push_event(11, 4'b1111, 4'b0000, 4'b1111, 4'b0101);
    reset = 1'b0; raw_in = 4'b1111;
    finish_scenario(30, "simultaneous");

    apply_reset('0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel front end for all switch and push-button inputs of the SoC.
- Each channel provides a synchroniser chain, a debounce filter and edge detection, plus an optional toggle (latching) mode.
- One shared prescaler replaces per-input free-running debounce counters, which saves area when many inputs are used.
- Outputs feed the CPU din/gpi buses, the reset and turbo-mode logic, and the debug LEDs.

Parameters:
- N_CH, 8: number of input channels.
- SYNC_STAGES, 2: flip-flops in each synchroniser chain. Minimum 2.
- PRESCALE, 50_000: clk cycles per debounce tick. 50_000 gives 1 ms at 50 MHz. Minimum 2.
- STABLE_TICKS, 30: consecutive ticks an input must differ from the committed level before the change is accepted. Minimum 1.
- RESET_VALUE, {N_CH{1'b0}}: committed level, and synchroniser contents, after reset.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when low, the prescaler is frozen, so no level commits occur. Synchronisers keep running.
- raw_in, input, N_CH: asynchronous raw switch/button inputs.
- toggle_en, input, N_CH: per channel; 1 selects toggle mode on toggle_out.
- level_out, output, N_CH: debounced, committed level.
- rise_pulse, output, N_CH: one-cycle pulse when level_out commits 0->1.
- fall_pulse, output, N_CH: one-cycle pulse when level_out commits 1->0.
- toggle_out, output, N_CH: flips on each rise commit when toggle_en=1; held when toggle_en=0.
- any_change, output, 1: OR of all rise_pulse and fall_pulse bits, registered in the same cycle.

Behaviour:
- Reset (checked at the clk edge while reset=1):
  - sync chains <= RESET_VALUE; level_out <= RESET_VALUE.
  - toggle_out, rise_pulse, fall_pulse, any_change <= 0.
  - prescaler and all channel counters <= 0.
  - Reset asserted mid-debounce discards the partial count. No pulse is emitted on reset entry or exit.
- Synchroniser: s[i] is raw_in[i] delayed by SYNC_STAGES edges. No filtering in the chain.
- Prescaler:
  - pcnt increments only when enable=1 and wraps from PRESCALE-1 to 0.
  - tick = enable && (pcnt == PRESCALE-1).
  - Width is clog2(PRESCALE).
- Channel counter cnt[i], width clog2(STABLE_TICKS)+1:
  - Any cycle with s[i]==level_out[i]: cnt <= 0. A bounce restarts the count.
  - tick with s[i]!=level_out[i] and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - tick with s[i]!=level_out[i] and cnt == STABLE_TICKS-1: commit. level_out[i] <= s[i]; cnt <= 0; the matching rise_pulse or fall_pulse is 1 for the next cycle only.
- Commit latency after s changes: between (STABLE_TICKS-1)*PRESCALE+1 and STABLE_TICKS*PRESCALE cycles, depending on prescaler phase. Add SYNC_STAGES from raw_in.
- Toggle: on a rise commit with toggle_en[i]=1, toggle_out[i] <= ~toggle_out[i], in the same edge as level_out. A change to toggle_en alone never alters toggle_out.
- Pulses are registered outputs, never combinational. All channels are independent, so simultaneous commits on several channels all pulse in the same cycle.
- enable low during a count: cnt holds its value. Counting resumes when enable returns high, unless s matched level_out in between.

Decomposition:
- Package input_conditioner_pkg: a clog2 function and the default constants (CLK_PERIOD_NS=20, TICK_NS=1_000_000, DEBOUNCE_MS=30).
- One sub-module, conditioner_channel: sync chain, counter, level/edge/toggle registers for one bit.
- conditioner_channel is instantiated N_CH times in a generate loop. The top holds the prescaler and any_change.

Test Plan (all scenarios use N_CH=4, SYNC_STAGES=2, PRESCALE=4, STABLE_TICKS=3, RESET_VALUE=4'b0000; cycle 0 is the first edge after reset deasserts):
- Clean rise: raw_in[0]=1 from cycle 0 -> level_out[0]=1 from cycle 12; rise_pulse[0] and any_change high in cycle 12 only.
- Bounce: raw_in[1]=1 at cycle 0, 0 at cycles 6-7, then 1 -> the count restarts, so no commit before cycle 20. The first rise_pulse[1] comes only after 3 full ticks of stable high.
- Toggle: toggle_en[2]=1, three clean press/release pairs -> toggle_out[2] sequence 1,0,1. Each flip coincides with rise_pulse[2]. fall_pulse[2] does not affect toggle_out.
- Freeze: enable=0 from cycle 5 to 50 with raw_in[3]=1 -> no commit during the freeze. Commit occurs at 50 + the remaining ticks.
- Reset mid-count: assert reset at cycle 9 during a pending rise -> all outputs 0 with no pulse. Full latency is required again after release.
- Simultaneous: raw_in=4'b1111 at cycle 0 -> all four rise_pulse bits high in the same cycle and any_change=1 for exactly one cycle.
